// File: rtl/cyclic_shift_seq_gen.sv
// PUCCH cyclic-shift phase sequencer: reduces a summed shift parameter mod 12 bit-serially,
// then streams ((sum * n) mod 12) * OUT_SCALE for n = 0..N_SC-1 over valid/ready.
module cyclic_shift_seq_gen #(
    parameter int unsigned SUM_W     = 16,
    parameter int unsigned N_SC      = 12,
    parameter int unsigned OUT_SCALE = 2,
    parameter int unsigned OUT_W     = 16,
    parameter int unsigned N_W       = (N_SC > 1) ? $clog2(N_SC) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start_valid,
    input  logic [SUM_W-1:0] i_sum_params,
    output logic             o_start_ready,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [OUT_W-1:0] o_phase,
    output logic [N_W-1:0]   o_n,
    output logic             o_last,
    output logic [3:0]       o_alpha_idx
);

    localparam int unsigned    CNT_W   = (SUM_W > 1) ? $clog2(SUM_W) : 1;
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(SUM_W - 1);
    localparam logic [N_W-1:0]   NLast   = N_W'(N_SC - 1);

    typedef enum logic [1:0] {StIdle, StReduce, StStream} state_e;

    state_e             state_q, state_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic [3:0]         r_q, r_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         alpha_q, alpha_d;
    logic [3:0]         acc_q, acc_d;
    logic [N_W-1:0]     n_q, n_d;
    logic               valid_q, valid_d;
    logic [OUT_W-1:0]   phase_q, phase_d;

    logic [4:0]         r_shift;
    logic [3:0]         r_red;
    logic [4:0]         acc_sum;
    logic [3:0]         acc_red;
    logic               start_fire;
    logic               xfer;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            sum_q   <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            alpha_q <= '0;
            acc_q   <= '0;
            n_q     <= '0;
            valid_q <= 1'b0;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            alpha_q <= alpha_d;
            acc_q   <= acc_d;
            n_q     <= n_d;
            valid_q <= valid_d;
            phase_q <= phase_d;
        end
    end

    // Restoring reduction step: remainder stays in 0..11, so {r, bit} never exceeds 23.
    always_comb begin
        r_shift = {r_q, sum_q[SUM_W-1]};
        r_red   = (r_shift >= 5'd12) ? 4'(r_shift - 5'd12) : r_shift[3:0];
        acc_sum = {1'b0, acc_q} + {1'b0, alpha_q};
        acc_red = (acc_sum >= 5'd12) ? 4'(acc_sum - 5'd12) : acc_sum[3:0];
    end

    always_comb begin
        start_fire = i_start_valid && o_start_ready;
        xfer       = valid_q && i_ready;
        state_d    = state_q;
        sum_d      = sum_q;
        r_d        = r_q;
        cnt_d      = cnt_q;
        alpha_d    = alpha_q;
        acc_d      = acc_q;
        n_d        = n_q;
        valid_d    = valid_q;
        phase_d    = phase_q;
        unique case (state_q)
            StIdle: begin
                if (start_fire) begin
                    sum_d   = i_sum_params;
                    r_d     = '0;
                    cnt_d   = '0;
                    state_d = StReduce;
                end
            end
            StReduce: begin
                sum_d = sum_q << 1;
                r_d   = r_red;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CntLast) begin
                    alpha_d = r_red;
                    acc_d   = '0;
                    n_d     = '0;
                    phase_d = '0;
                    valid_d = 1'b1;
                    state_d = StStream;
                end
            end
            StStream: begin
                if (xfer) begin
                    if (n_q == NLast) begin
                        valid_d = 1'b0;
                        state_d = StIdle;
                    end else begin
                        n_d     = n_q + N_W'(1);
                        acc_d   = acc_red;
                        phase_d = OUT_W'(acc_red) * OUT_W'(OUT_SCALE);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        o_start_ready = (state_q == StIdle) && !i_rst;
        o_last        = valid_q && (n_q == NLast);
        o_valid       = valid_q;
        o_phase       = phase_q;
        o_n           = n_q;
        o_alpha_idx   = alpha_q;
    end

endmodule

// File: tb/tb_cyclic_shift_seq_gen.sv
// Bench for cyclic_shift_seq_gen: two instances (12 and 24 subcarriers) checked against an
// arithmetic model of (sum * n) mod 12 under fixed, alternating and random backpressure.
module tb_cyclic_shift_seq_gen;

    localparam int unsigned SUM_W     = 16;
    localparam int unsigned OUT_SCALE = 2;
    localparam int unsigned OUT_W     = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_v;
    logic             ready;
    logic [SUM_W-1:0] sum;
    logic             sel;

    logic             a_sv, a_sr, a_valid, a_last;
    logic [OUT_W-1:0] a_phase;
    logic [3:0]       a_n, a_alpha;
    logic             b_sv, b_sr, b_valid, b_last;
    logic [OUT_W-1:0] b_phase;
    logic [4:0]       b_n;
    logic [3:0]       b_alpha;

    logic             obs_sr, obs_valid, obs_last;
    logic [OUT_W-1:0] obs_phase;
    logic [4:0]       obs_n;
    logic [3:0]       obs_alpha;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign a_sv = start_v && !sel;
    assign b_sv = start_v && sel;

    always_comb begin
        obs_sr    = sel ? b_sr    : a_sr;
        obs_valid = sel ? b_valid : a_valid;
        obs_last  = sel ? b_last  : a_last;
        obs_phase = sel ? b_phase : a_phase;
        obs_n     = sel ? b_n     : {1'b0, a_n};
        obs_alpha = sel ? b_alpha : a_alpha;
    end

    cyclic_shift_seq_gen #(
        .SUM_W(SUM_W), .N_SC(12), .OUT_SCALE(OUT_SCALE), .OUT_W(OUT_W)
    ) u_dut_a (
        .i_clk(clk), .i_rst(rst), .i_start_valid(a_sv), .i_sum_params(sum),
        .o_start_ready(a_sr), .o_valid(a_valid), .i_ready(ready), .o_phase(a_phase),
        .o_n(a_n), .o_last(a_last), .o_alpha_idx(a_alpha)
    );

    cyclic_shift_seq_gen #(
        .SUM_W(SUM_W), .N_SC(24), .OUT_SCALE(OUT_SCALE), .OUT_W(OUT_W)
    ) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_start_valid(b_sv), .i_sum_params(sum),
        .o_start_ready(b_sr), .o_valid(b_valid), .i_ready(ready), .o_phase(b_phase),
        .o_n(b_n), .o_last(b_last), .o_alpha_idx(b_alpha)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic longint exp_phase(input longint s, input longint n);
        return ((s * n) % 12) * OUT_SCALE;
    endfunction

    // mode: 0 = always ready, 1 = ready alternates 1,0,..., 2 = random ready.
    // abort_at >= 0 pulses reset for one cycle when beat abort_at is presented.
    task automatic run_req(input logic [SUM_W-1:0] s, input int mode, input bit hold,
                           input int abort_at);
        int  nsc;
        int  k;
        int  lat;
        int  guard;
        int  tog;
        bit  rdy;
        nsc   = sel ? 24 : 12;
        guard = 0;
        while (!obs_sr && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!obs_sr) begin
            check_val("start_ready_timeout", 0, 1);
            return;
        end
        sum     = s;
        start_v = 1'b1;
        @(negedge clk);
        check_val("start_ready_after_accept", obs_sr, 0);
        if (!hold) start_v = 1'b0;
        lat = 0;
        while (!obs_valid && lat < 100) begin
            check_val("start_ready_in_reduce", obs_sr, 0);
            lat++;
            @(negedge clk);
        end
        check_val("first_beat_latency", lat, SUM_W);
        check_val("alpha_idx", obs_alpha, s % 12);
        k     = 0;
        tog   = 0;
        guard = 0;
        while (k < nsc && guard < 2000) begin
            guard++;
            if (!obs_valid) begin
                check_val("valid_dropped_mid_stream", obs_valid, 1);
                break;
            end
            check_val("beat_n", obs_n, k);
            check_val("beat_phase", obs_phase, exp_phase(s, k));
            check_val("beat_last", obs_last, (k == nsc - 1));
            check_val("start_ready_in_stream", obs_sr, 0);
            if (abort_at == k) begin
                rst = 1'b1;
                #1;
                check_val("start_ready_in_reset", obs_sr, 0);
                @(negedge clk);
                check_val("rst_valid", obs_valid, 0);
                check_val("rst_n", obs_n, 0);
                check_val("rst_alpha", obs_alpha, 0);
                check_val("rst_phase", obs_phase, 0);
                check_val("rst_last", obs_last, 0);
                rst = 1'b0;
                #1;
                check_val("start_ready_after_reset", obs_sr, 1);
                repeat (3) begin
                    @(negedge clk);
                    check_val("no_beats_after_reset", obs_valid, 0);
                end
                return;
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (tog % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            tog++;
            ready = rdy;
            if (rdy) k++;
            @(negedge clk);
        end
        if (k < nsc) check_val("stream_beat_count", k, nsc);
        ready = 1'b1;
        check_val("valid_after_last", obs_valid, 0);
        check_val("start_ready_after_last", obs_sr, 1);
        check_val("last_after_last", obs_last, 0);
        check_val("alpha_held", obs_alpha, s % 12);
    endtask

    initial begin
        rst     = 1'b1;
        start_v = 1'b0;
        ready   = 1'b1;
        sum     = '0;
        sel     = 1'b0;
        repeat (2) @(negedge clk);
        check_val("reset_valid", obs_valid, 0);
        check_val("reset_n", obs_n, 0);
        check_val("reset_phase", obs_phase, 0);
        check_val("reset_alpha", obs_alpha, 0);
        check_val("reset_last", obs_last, 0);
        check_val("reset_start_ready", obs_sr, 0);
        check_val("reset_start_ready_b", b_sr, 0);
        rst = 1'b0;
        #1;
        check_val("idle_start_ready", obs_sr, 1);
        @(negedge clk);

        run_req(16'd1, 0, 1'b0, -1);
        run_req(16'hFFFF, 0, 1'b0, -1);
        run_req(16'd12, 0, 1'b0, -1);
        run_req(16'd5, 1, 1'b0, -1);

        sel = 1'b1;
        @(negedge clk);
        run_req(16'd7, 0, 1'b0, -1);
        run_req(16'($urandom_range(0, 65535)), 2, 1'b0, -1);
        sel = 1'b0;
        @(negedge clk);

        // Start held high across a whole request, then re-accepted immediately with sum 2.
        run_req(16'd9, 0, 1'b1, -1);
        run_req(16'd2, 0, 1'b0, -1);

        run_req(16'd3, 0, 1'b0, 5);
        run_req(16'd1, 0, 1'b0, -1);

        for (int i = 0; i < 6; i++) begin
            sel = 1'(i % 2);
            @(negedge clk);
            run_req(16'($urandom_range(0, 65535)), 2, 1'b0, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
